// File: rtl/pci_burst_target.sv
// pci_burst_target
//   PCI memory target with multi-word burst reads and writes. Claims memory
//   read (0110) and memory write (0111) cycles that fall inside a window of
//   MEM_DEPTH 32-bit words at BASE_ADDR, transfers one word per data phase
//   with byte enables, inserts WAIT_STATES cycles before every TRDY, and
//   disconnects with STOP when a burst reaches the last word of the array.
//
// Parameters
//   BASE_ADDR   byte base of the window, aligned to MEM_DEPTH*4
//   MEM_DEPTH   number of 32-bit words, power of two, 2..256
//   WAIT_STATES target wait cycles before each data phase, 0..7
//
// Ports
//   CLK     bus clock, all state changes on the rising edge
//   RST     synchronous active-high reset
//   FRAME   active-low transaction frame from the master
//   AD      multiplexed address/data; driven only in the read data state
//   CBE     command in the address phase, active-low byte enables in data
//   IRDY    active-low initiator ready
//   TRDY    active-low target ready (registered)
//   DEVSEL  active-low device select (registered)
//   STOP    active-low disconnect request (registered)

module pci_burst_target #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
   parameter int unsigned MEM_DEPTH   = 16,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        FRAME,
   inout  wire  [31:0] AD,
   input  logic [3:0]  CBE,
   input  logic        IRDY,
   output logic        TRDY,
   output logic        DEVSEL,
   output logic        STOP
);

   localparam int unsigned    IdxW    = $clog2(MEM_DEPTH);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(MEM_DEPTH - 1);
   localparam logic [3:0]     WaitCnt = 4'(WAIT_STATES);
   localparam bit             NoWait  = (WAIT_STATES == 0);

   localparam logic [3:0] CmdMemRead  = 4'b0110;
   localparam logic [3:0] CmdMemWrite = 4'b0111;

   typedef enum logic [2:0] {
      StIdle,
      StIgnore,
      StTurn,
      StWdata,
      StRdata,
      StBackoff
   } state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [3:0]      wcnt_q, wcnt_d;
   logic            trdy_q, trdy_d;
   logic            devsel_q, devsel_d;
   logic            stop_q, stop_d;
   logic            resync_q, resync_d;
   logic [31:0]     mem_q [MEM_DEPTH];
   logic [31:0]     mem_d [MEM_DEPTH];

   logic            addr_hit;
   logic [IdxW-1:0] addr_idx;
   logic            cmd_rd;
   logic            cmd_wr;
   logic            xfer;
   logic            mem_we;
   logic [IdxW-1:0] idx_inc;
   logic [3:0]      wcnt_inc;

   assign addr_hit = (AD[31:IdxW+2] == BASE_ADDR[31:IdxW+2]);
   assign addr_idx = AD[IdxW+1:2];
   assign cmd_rd   = (CBE == CmdMemRead);
   assign cmd_wr   = (CBE == CmdMemWrite);
   assign xfer     = !IRDY && !trdy_q;
   assign idx_inc  = idx_q + IdxW'(1);
   assign wcnt_inc = wcnt_q + 4'd1;

   // After reset the bus may be mid-transaction; stay deaf until the bus has
   // been seen idle (FRAME and IRDY both high) so stray data is not decoded
   // as an address.
   assign resync_d = resync_q && !(FRAME && IRDY);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wcnt_d   = wcnt_q;
      trdy_d   = trdy_q;
      devsel_d = devsel_q;
      stop_d   = stop_q;
      mem_we   = 1'b0;

      unique case (state_q)
         StIdle: begin
            trdy_d   = 1'b1;
            devsel_d = 1'b1;
            stop_d   = 1'b1;
            wcnt_d   = '0;
            if (!FRAME) begin
               if (!resync_q && addr_hit && (cmd_rd || cmd_wr)) begin
                  idx_d    = addr_idx;
                  devsel_d = 1'b0;
                  if (cmd_wr) begin
                     state_d = StWdata;
                     trdy_d  = !NoWait;
                     stop_d  = !(NoWait && (addr_idx == LastIdx));
                  end else begin
                     state_d = StTurn;
                  end
               end else begin
                  state_d = StIgnore;
               end
            end
         end

         StIgnore: begin
            if (FRAME && IRDY) begin
               state_d = StIdle;
            end
         end

         // Bus turnaround: the master releases AD before we drive it.
         StTurn: begin
            state_d = StRdata;
            wcnt_d  = '0;
            trdy_d  = !NoWait;
            stop_d  = !(NoWait && (idx_q == LastIdx));
         end

         StWdata, StRdata: begin
            if (xfer) begin
               mem_we = (state_q == StWdata);
               wcnt_d = '0;
               if (FRAME) begin
                  state_d  = StIdle;
                  trdy_d   = 1'b1;
                  devsel_d = 1'b1;
                  stop_d   = 1'b1;
               end else if (idx_q == LastIdx) begin
                  // Master wants more but the array is exhausted.
                  state_d = StBackoff;
                  trdy_d  = 1'b1;
                  stop_d  = 1'b0;
               end else begin
                  idx_d  = idx_inc;
                  trdy_d = !NoWait;
                  stop_d = !(NoWait && (idx_inc == LastIdx));
               end
            end else if (trdy_q) begin
               wcnt_d = wcnt_inc;
               if (wcnt_inc == WaitCnt) begin
                  trdy_d = 1'b0;
                  stop_d = (idx_q != LastIdx);
               end
            end
            // TRDY low with IRDY high: master stall, everything holds.
         end

         StBackoff: begin
            trdy_d   = 1'b1;
            devsel_d = 1'b0;
            stop_d   = 1'b0;
            if (FRAME) begin
               state_d  = StIdle;
               devsel_d = 1'b1;
               stop_d   = 1'b1;
            end
         end

         default: begin
            state_d  = StIdle;
            trdy_d   = 1'b1;
            devsel_d = 1'b1;
            stop_d   = 1'b1;
         end
      endcase
   end

   // Byte-lane merge of the write data into the addressed word.
   always_comb begin
      mem_d = mem_q;
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (!CBE[i]) begin
               mem_d[idx_q][8*i +: 8] = AD[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         wcnt_q   <= '0;
         trdy_q   <= 1'b1;
         devsel_q <= 1'b1;
         stop_q   <= 1'b1;
         resync_q <= 1'b1;
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         wcnt_q   <= wcnt_d;
         trdy_q   <= trdy_d;
         devsel_q <= devsel_d;
         stop_q   <= stop_d;
         resync_q <= resync_d;
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   assign TRDY   = trdy_q;
   assign DEVSEL = devsel_q;
   assign STOP   = stop_q;

   // Read data follows idx combinationally for the whole read data state.
   assign AD = (state_q == StRdata) ? mem_q[idx_q] : 32'bz;

endmodule
